// File: rtl/mem_arbiter_if.sv
// Bundle between the requesters, the memory unit and mem_arbiter.
// The arbiter takes the slave view; the surrounding logic takes master.
interface mem_arbiter_if;
    logic        ena;
    logic        in_flush;
    logic        in_io_full;
    logic        in_fetch_req;
    logic [31:0] in_fetch_addr;
    logic        out_fetch_ok;
    logic [31:0] out_fetch_data;
    logic        in_load_req;
    logic [31:0] in_load_addr;
    logic [2:0]  in_load_size;
    logic        out_load_ok;
    logic [31:0] out_load_data;
    logic        in_store_req;
    logic [31:0] in_store_addr;
    logic [2:0]  in_store_size;
    logic [31:0] in_store_data;
    logic        out_store_ok;
    logic        out_mem_ena;
    logic        out_mem_iswrite;
    logic [31:0] out_mem_addr;
    logic [2:0]  out_mem_size;
    logic [31:0] out_mem_data;
    logic        in_mem_ok;
    logic [31:0] in_mem_data;
    logic        out_busy;

    modport slave (
        input  ena, in_flush, in_io_full,
        input  in_fetch_req, in_fetch_addr,
        input  in_load_req, in_load_addr, in_load_size,
        input  in_store_req, in_store_addr, in_store_size,
        input  in_store_data,
        input  in_mem_ok, in_mem_data,
        output out_fetch_ok, out_fetch_data,
        output out_load_ok, out_load_data,
        output out_store_ok,
        output out_mem_ena, out_mem_iswrite, out_mem_addr,
        output out_mem_size, out_mem_data,
        output out_busy
    );

    modport master (
        output ena, in_flush, in_io_full,
        output in_fetch_req, in_fetch_addr,
        output in_load_req, in_load_addr, in_load_size,
        output in_store_req, in_store_addr, in_store_size,
        output in_store_data,
        output in_mem_ok, in_mem_data,
        input  out_fetch_ok, out_fetch_data,
        input  out_load_ok, out_load_data,
        input  out_store_ok,
        input  out_mem_ena, out_mem_iswrite, out_mem_addr,
        input  out_mem_size, out_mem_data,
        input  out_busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// One-at-a-time owner of the memory unit request port, shared by
// instruction fetch, load and committed store.
module mem_arbiter #(
    parameter int unsigned FETCH_STARVE_LIMIT = 4,
    parameter logic [1:0]  IO_ADDR_HI         = 2'b11
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {OWN_FETCH, OWN_LOAD, OWN_STORE} owner_t;

    localparam int SW = $clog2(FETCH_STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(FETCH_STARVE_LIMIT);

    state_t        state;
    state_t        state_nx;
    owner_t        owner;
    logic          discard;
    logic [SW-1:0] streak;
    logic          mem_ena_q;
    logic          iswrite_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [2:0]    size_q;
    logic [31:0]   fetch_data_q;
    logic [31:0]   load_data_q;

    logic store_el, load_el, fetch_el, starve;
    logic grant_store, grant_load, grant_fetch, grant;
    logic kill, accept;
    logic done_ok, fetch_ok, load_ok, store_ok, busy;

    always_comb begin
        store_el = bus.in_store_req &&
                   !(bus.in_io_full &&
                     bus.in_store_addr[17:16] == IO_ADDR_HI);
        load_el  = bus.in_load_req && !bus.in_flush;
        fetch_el = bus.in_fetch_req && !bus.in_flush;
        starve   = fetch_el && (streak >= STREAK_MAX);
        grant_store = !starve && store_el;
        grant_load  = !starve && !store_el && load_el;
        grant_fetch = starve || (fetch_el && !store_el && !load_el);
        grant  = (state == IDLE) &&
                 (grant_store || grant_load || grant_fetch);
        // Flush only kills speculative owners; stores are committed.
        kill   = bus.in_flush && (owner != OWN_STORE);
        accept = (state == BUSY) && bus.in_mem_ok && !discard && !kill;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (bus.ena) begin
            unique case (state)
                IDLE:    if (grant) state_nx = BUSY;
                BUSY:    if (bus.in_mem_ok) state_nx = DONE;
                DONE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner        <= OWN_FETCH;
            discard      <= 1'b0;
            streak       <= '0;
            mem_ena_q    <= 1'b0;
            iswrite_q    <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= '0;
            fetch_data_q <= '0;
            load_data_q  <= '0;
        end else if (bus.ena) begin
            mem_ena_q <= grant;
            if (grant) begin
                discard <= 1'b0;
                if (grant_fetch || !bus.in_fetch_req) begin
                    streak <= '0;
                end else if (streak != STREAK_MAX) begin
                    streak <= streak + 1'b1;
                end
                unique case (1'b1)
                    grant_store: begin
                        owner     <= OWN_STORE;
                        iswrite_q <= 1'b1;
                        addr_q    <= bus.in_store_addr;
                        size_q    <= bus.in_store_size;
                        wdata_q   <= bus.in_store_data;
                    end
                    grant_load: begin
                        owner     <= OWN_LOAD;
                        iswrite_q <= 1'b0;
                        addr_q    <= bus.in_load_addr;
                        size_q    <= bus.in_load_size;
                        wdata_q   <= '0;
                    end
                    default: begin
                        owner     <= OWN_FETCH;
                        iswrite_q <= 1'b0;
                        addr_q    <= bus.in_fetch_addr;
                        size_q    <= 3'd4;
                        wdata_q   <= '0;
                    end
                endcase
            end
            if (state == BUSY) begin
                if (kill) discard <= 1'b1;
                if (accept && owner == OWN_FETCH) begin
                    fetch_data_q <= bus.in_mem_data;
                end
                if (accept && owner == OWN_LOAD) begin
                    load_data_q <= bus.in_mem_data;
                end
            end
        end
    end

    always_comb begin
        done_ok  = bus.ena && (state == DONE) && !discard;
        fetch_ok = done_ok && (owner == OWN_FETCH);
        load_ok  = done_ok && (owner == OWN_LOAD);
        store_ok = done_ok && (owner == OWN_STORE);
        busy     = (state != IDLE);
    end

    assign bus.out_fetch_ok    = fetch_ok;
    assign bus.out_load_ok     = load_ok;
    assign bus.out_store_ok    = store_ok;
    assign bus.out_busy        = busy;
    // A held pulse stays invisible while the unit is stalled.
    assign bus.out_mem_ena     = mem_ena_q && bus.ena;
    assign bus.out_mem_iswrite = iswrite_q;
    assign bus.out_mem_addr    = addr_q;
    assign bus.out_mem_size    = size_q;
    assign bus.out_mem_data    = wdata_q;
    assign bus.out_fetch_data  = fetch_data_q;
    assign bus.out_load_data   = load_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a latency-programmable memory
// responder and level-style requesters.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .FETCH_STARVE_LIMIT(4),
        .IO_ADDR_HI(2'b11)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int pass_cnt = 0;
    int total    = 0;

    int fetch_issue = 0, fetch_cancel = 0, fetch_done = 0;
    int load_issue  = 0, load_cancel  = 0, load_done  = 0;
    int store_issue = 0, store_done   = 0;
    int ena_viol    = 0;
    logic prev_mem_ena = 1'b0;

    int          mem_lat   = 1;
    logic [31:0] mem_rdata = '0;
    logic        abort;

    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    logic [2:0]  log_size[$];
    logic        log_wr[$];

    assign bus.in_fetch_req = (fetch_issue != fetch_done + fetch_cancel);
    assign bus.in_load_req  = (load_issue != load_done + load_cancel);
    assign bus.in_store_req = (store_issue != store_done);

    // Memory unit model: logs each request, answers after mem_lat cycles.
    initial begin
        bus.in_mem_ok   = 1'b0;
        bus.in_mem_data = '0;
        forever begin
            @(negedge clk);
            if (bus.out_mem_ena === 1'b1 && !rst) begin
                log_addr.push_back(bus.out_mem_addr);
                log_data.push_back(bus.out_mem_data);
                log_size.push_back(bus.out_mem_size);
                log_wr.push_back(bus.out_mem_iswrite);
                abort = 1'b0;
                for (int i = 1; i < mem_lat; i++) begin
                    @(negedge clk);
                    if (rst) begin
                        abort = 1'b1;
                        break;
                    end
                end
                if (!abort) begin
                    bus.in_mem_ok   = 1'b1;
                    bus.in_mem_data = mem_rdata;
                    @(negedge clk);
                    bus.in_mem_ok   = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus.out_fetch_ok === 1'b1) fetch_done++;
            if (bus.out_load_ok === 1'b1)  load_done++;
            if (bus.out_store_ok === 1'b1) store_done++;
            if (bus.out_mem_ena === 1'b1 && prev_mem_ena === 1'b1) ena_viol++;
            prev_mem_ena = bus.out_mem_ena;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) step();
        settle();
        total++;
        if ({bus.out_mem_ena, bus.out_mem_iswrite, bus.out_mem_addr,
             bus.out_mem_size, bus.out_mem_data, bus.out_fetch_ok,
             bus.out_load_ok, bus.out_store_ok, bus.out_fetch_data,
             bus.out_load_data, bus.out_busy} !== '0)
            $display("FAIL reset_outputs: got busy=%b ena=%b addr=%h, want all 0",
                     bus.out_busy, bus.out_mem_ena, bus.out_mem_addr);
        else pass_cnt++;
        step();
        rst = 1'b0;
    endtask

    task automatic test_single_fetch();
        int f0 = fetch_done;
        int n0 = log_addr.size();
        mem_lat   = 5;
        mem_rdata = 32'h00A0_0093;
        bus.in_fetch_addr = 32'h0000_1000;
        step();
        fetch_issue++;
        settle();
        total++;
        if (bus.out_mem_ena !== 1'b0)
            $display("FAIL fetch_ena_early: got %b want 0", bus.out_mem_ena);
        else pass_cnt++;
        settle();
        total++;
        if (bus.out_mem_ena !== 1'b1)
            $display("FAIL fetch_ena: got %b want 1", bus.out_mem_ena);
        else pass_cnt++;
        total++;
        if ({bus.out_mem_iswrite, bus.out_mem_size, bus.out_mem_addr}
            !== {1'b0, 3'd4, 32'h0000_1000})
            $display("FAIL fetch_req: got wr=%b size=%0d addr=%h want 0/4/00001000",
                     bus.out_mem_iswrite, bus.out_mem_size, bus.out_mem_addr);
        else pass_cnt++;
        for (int i = 0; i < 30 && fetch_done == f0; i++) settle();
        total++;
        if ({bus.out_fetch_ok, bus.out_fetch_data} !== {1'b1, 32'h00A0_0093})
            $display("FAIL fetch_ok_data: got ok=%b data=%h want 1/00a00093",
                     bus.out_fetch_ok, bus.out_fetch_data);
        else pass_cnt++;
        settle();
        total++;
        if ({bus.out_fetch_ok, bus.out_busy} !== 2'b00)
            $display("FAIL fetch_idle: got ok=%b busy=%b want 0/0",
                     bus.out_fetch_ok, bus.out_busy);
        else pass_cnt++;
        repeat (5) settle();
        total++;
        if (fetch_done != f0 + 1 || log_addr.size() != n0 + 1)
            $display("FAIL fetch_once: got oks=%0d reqs=%0d want 1/1",
                     fetch_done - f0, log_addr.size() - n0);
        else pass_cnt++;
    endtask

    task automatic test_priority();
        int f0 = fetch_done;
        int l0 = load_done;
        int s0 = store_done;
        int n0 = log_addr.size();
        mem_lat   = 3;
        mem_rdata = 32'h1234_5678;
        bus.in_store_addr = 32'h0000_0100;
        bus.in_store_size = 3'd4;
        bus.in_store_data = 32'hCAFE_F00D;
        bus.in_load_addr  = 32'h0000_0200;
        bus.in_load_size  = 3'd2;
        bus.in_fetch_addr = 32'h0000_1004;
        step();
        store_issue++;
        load_issue++;
        fetch_issue++;
        for (int i = 0; i < 60 && fetch_done == f0; i++) settle();
        repeat (4) settle();
        total++;
        if (log_addr.size() != n0 + 3)
            $display("FAIL prio_count: got %0d want 3", log_addr.size() - n0);
        else pass_cnt++;
        total++;
        if (log_addr.size() < n0 + 3 ||
            {log_wr[n0], log_addr[n0], log_size[n0], log_data[n0]}
            !== {1'b1, 32'h0000_0100, 3'd4, 32'hCAFE_F00D})
            $display("FAIL prio_first_store: got addr=%h want 00000100 write",
                     (log_addr.size() > n0) ? log_addr[n0] : 32'hX);
        else pass_cnt++;
        total++;
        if (log_addr.size() < n0 + 3 ||
            {log_wr[n0+1], log_addr[n0+1], log_size[n0+1],
             log_wr[n0+2], log_addr[n0+2], log_size[n0+2]}
            !== {1'b0, 32'h0000_0200, 3'd2, 1'b0, 32'h0000_1004, 3'd4})
            $display("FAIL prio_load_fetch: got order mismatch, want load 200 then fetch 1004");
        else pass_cnt++;
        total++;
        if (fetch_done != f0 + 1 || load_done != l0 + 1 || store_done != s0 + 1)
            $display("FAIL prio_oks: got f=%0d l=%0d s=%0d want 1/1/1",
                     fetch_done - f0, load_done - l0, store_done - s0);
        else pass_cnt++;
        total++;
        if ({bus.out_load_data, bus.out_fetch_data} !== {2{32'h1234_5678}})
            $display("FAIL prio_data: got l=%h f=%h want 12345678",
                     bus.out_load_data, bus.out_fetch_data);
        else pass_cnt++;
    endtask

    task automatic test_starvation();
        logic [11:0] obs = '0;
        int f0 = fetch_done;
        int l0 = load_done;
        int n0 = log_addr.size();
        mem_lat = 1;
        bus.in_fetch_addr = 32'h0000_1008;
        bus.in_load_addr  = 32'h0000_0300;
        bus.in_load_size  = 3'd4;
        step();
        load_issue  += 10;
        fetch_issue += 2;
        for (int i = 0; i < 200 &&
             (fetch_done != f0 + 2 || load_done != l0 + 10); i++) settle();
        repeat (3) settle();
        total++;
        if (log_addr.size() != n0 + 12)
            $display("FAIL starve_count: got %0d want 12", log_addr.size() - n0);
        else pass_cnt++;
        for (int i = 0; i < 12; i++) begin
            if (n0 + i < log_addr.size())
                obs[11-i] = (log_addr[n0+i] == 32'h0000_1008);
        end
        total++;
        if (obs !== 12'b0000_1000_0100)
            $display("FAIL starve_order: got %b want 000010000100", obs);
        else pass_cnt++;
    endtask

    task automatic test_io_backpressure();
        int l0 = load_done;
        int s0 = store_done;
        int n0 = log_addr.size();
        mem_lat   = 2;
        mem_rdata = 32'h0000_5A5A;
        bus.in_store_addr = 32'h0003_0000;
        bus.in_store_size = 3'd1;
        bus.in_store_data = 32'h0000_00AB;
        bus.in_load_addr  = 32'h0000_0400;
        bus.in_load_size  = 3'd1;
        bus.in_io_full    = 1'b1;
        step();
        store_issue++;
        load_issue++;
        for (int i = 0; i < 40 && load_done == l0; i++) settle();
        repeat (6) settle();
        total++;
        if (log_addr.size() != n0 + 1 || store_done != s0 ||
            log_wr[n0] !== 1'b0 || log_addr[n0] !== 32'h0000_0400)
            $display("FAIL io_blocked: got reqs=%0d stores=%0d want 1 load/0 stores",
                     log_addr.size() - n0, store_done - s0);
        else pass_cnt++;
        step();
        bus.in_io_full = 1'b0;
        for (int i = 0; i < 40 && store_done == s0; i++) settle();
        total++;
        if (log_addr.size() != n0 + 2 ||
            {log_wr[n0+1], log_addr[n0+1], log_size[n0+1], log_data[n0+1]}
            !== {1'b1, 32'h0003_0000, 3'd1, 32'h0000_00AB})
            $display("FAIL io_store: got reqs=%0d want store 30000/ab",
                     log_addr.size() - n0);
        else pass_cnt++;
        total++;
        if (bus.out_load_data !== 32'h0000_5A5A)
            $display("FAIL io_load_data: got %h want 00005a5a", bus.out_load_data);
        else pass_cnt++;
    endtask

    task automatic test_flush_inflight();
        int l0 = load_done;
        int s0 = store_done;
        int n0 = log_addr.size();
        mem_lat   = 6;
        mem_rdata = 32'hDEAD_BEEF;
        bus.in_load_addr = 32'h0000_0500;
        bus.in_load_size = 3'd4;
        step();
        load_issue++;
        for (int i = 0; i < 10 && log_addr.size() == n0; i++) settle();
        step();
        bus.in_flush      = 1'b1;
        load_cancel++;
        bus.in_store_addr = 32'h0000_0600;
        bus.in_store_size = 3'd4;
        bus.in_store_data = 32'h1122_3344;
        store_issue++;
        step();
        bus.in_flush = 1'b0;
        for (int i = 0; i < 60 && store_done == s0; i++) settle();
        repeat (3) settle();
        total++;
        if (load_done != l0)
            $display("FAIL flush_no_ok: got %0d load oks want 0", load_done - l0);
        else pass_cnt++;
        total++;
        if (bus.out_load_data !== 32'h0000_5A5A)
            $display("FAIL flush_data_hold: got %h want 00005a5a", bus.out_load_data);
        else pass_cnt++;
        total++;
        if (store_done != s0 + 1 || log_addr.size() != n0 + 2 ||
            {log_wr[n0+1], log_addr[n0+1], log_data[n0+1]}
            !== {1'b1, 32'h0000_0600, 32'h1122_3344})
            $display("FAIL flush_store: got stores=%0d reqs=%0d want 1/2",
                     store_done - s0, log_addr.size() - n0);
        else pass_cnt++;
    endtask

    task automatic test_flush_edges();
        int l0 = load_done;
        int s0 = store_done;
        mem_lat   = 3;
        mem_rdata = 32'h0BAD_0001;
        bus.in_load_addr = 32'h0000_0700;
        step();
        bus.in_flush = 1'b1;
        load_issue++;
        step();
        bus.in_flush = 1'b0;
        settle();
        total++;
        if ({bus.out_mem_ena, bus.out_busy} !== 2'b00)
            $display("FAIL flush_blocks_load: got ena=%b busy=%b want 0/0",
                     bus.out_mem_ena, bus.out_busy);
        else pass_cnt++;
        settle();
        total++;
        if (bus.out_mem_ena !== 1'b1)
            $display("FAIL load_after_flush: got ena=%b want 1", bus.out_mem_ena);
        else pass_cnt++;
        for (int i = 0; i < 20 && bus.in_mem_ok !== 1'b1; i++) settle();
        bus.in_flush = 1'b1;
        load_cancel++;
        step();
        bus.in_flush = 1'b0;
        repeat (3) settle();
        total++;
        if (load_done != l0 || bus.out_load_data !== 32'h0000_5A5A)
            $display("FAIL flush_with_ok: got oks=%0d data=%h want 0/00005a5a",
                     load_done - l0, bus.out_load_data);
        else pass_cnt++;
        bus.in_store_addr = 32'h0000_0800;
        step();
        bus.in_flush = 1'b1;
        store_issue++;
        step();
        bus.in_flush = 1'b0;
        settle();
        total++;
        if ({bus.out_mem_ena, bus.out_mem_iswrite} !== 2'b11)
            $display("FAIL flush_store_grant: got ena=%b wr=%b want 1/1",
                     bus.out_mem_ena, bus.out_mem_iswrite);
        else pass_cnt++;
        for (int i = 0; i < 20 && store_done == s0; i++) settle();
        total++;
        if (store_done != s0 + 1)
            $display("FAIL flush_store_ok: got %0d want 1", store_done - s0);
        else pass_cnt++;
    endtask

    task automatic test_ena_hold();
        int f0 = fetch_done;
        mem_lat   = 2;
        mem_rdata = 32'h0000_0297;
        bus.in_fetch_addr = 32'h0000_2000;
        step();
        bus.ena = 1'b0;
        fetch_issue++;
        repeat (3) settle();
        total++;
        if ({bus.out_mem_ena, bus.out_busy} !== 2'b00)
            $display("FAIL ena_hold: got ena=%b busy=%b want 0/0",
                     bus.out_mem_ena, bus.out_busy);
        else pass_cnt++;
        step();
        bus.ena = 1'b1;
        settle();
        settle();
        total++;
        if (bus.out_mem_ena !== 1'b1)
            $display("FAIL ena_resume: got %b want 1", bus.out_mem_ena);
        else pass_cnt++;
        for (int i = 0; i < 20 && fetch_done == f0; i++) settle();
        total++;
        if (bus.out_fetch_data !== 32'h0000_0297)
            $display("FAIL ena_fetch_data: got %h want 00000297", bus.out_fetch_data);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int f0;
        int n0;
        mem_lat = 10;
        bus.in_fetch_addr = 32'h0000_3000;
        step();
        fetch_issue++;
        for (int i = 0; i < 10 && bus.out_busy !== 1'b1; i++) settle();
        step();
        rst = 1'b1;
        fetch_cancel++;
        step();
        settle();
        total++;
        if ({bus.out_mem_ena, bus.out_mem_iswrite, bus.out_mem_addr,
             bus.out_mem_size, bus.out_mem_data, bus.out_fetch_ok,
             bus.out_load_ok, bus.out_store_ok, bus.out_fetch_data,
             bus.out_load_data, bus.out_busy} !== '0)
            $display("FAIL reset_mid_outputs: got busy=%b addr=%h fdata=%h ldata=%h want 0",
                     bus.out_busy, bus.out_mem_addr, bus.out_fetch_data,
                     bus.out_load_data);
        else pass_cnt++;
        step();
        rst = 1'b0;
        f0 = fetch_done;
        n0 = log_addr.size();
        mem_lat   = 2;
        mem_rdata = 32'h0000_0513;
        bus.in_fetch_addr = 32'h0000_3004;
        step();
        fetch_issue++;
        for (int i = 0; i < 30 && fetch_done == f0; i++) settle();
        total++;
        if (fetch_done != f0 + 1 || bus.out_fetch_data !== 32'h0000_0513)
            $display("FAIL reset_refetch: got oks=%0d data=%h want 1/00000513",
                     fetch_done - f0, bus.out_fetch_data);
        else pass_cnt++;
        total++;
        if (log_addr.size() != n0 + 1 || log_addr[n0] !== 32'h0000_3004)
            $display("FAIL reset_refetch_addr: got reqs=%0d want 1 at 00003004",
                     log_addr.size() - n0);
        else pass_cnt++;
    endtask

    initial begin
        bus.ena           = 1'b1;
        bus.in_flush      = 1'b0;
        bus.in_io_full    = 1'b0;
        bus.in_fetch_addr = '0;
        bus.in_load_addr  = '0;
        bus.in_load_size  = 3'd4;
        bus.in_store_addr = '0;
        bus.in_store_size = 3'd4;
        bus.in_store_data = '0;
        test_reset();
        test_single_fetch();
        test_priority();
        test_starvation();
        test_io_backpressure();
        test_flush_inflight();
        test_flush_edges();
        test_ena_hold();
        test_reset_mid();
        repeat (3) settle();
        total++;
        if (ena_viol != 0)
            $display("FAIL mem_ena_consecutive: got %0d violations want 0", ena_viol);
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-owner arbiter that shares the byte-serial memory unit's request port between three requesters: instruction fetch, load, and committed store. It sits between the fetcher/load-store buffer and the memory unit. It issues one request at a time, waits for that request to complete, and routes the completion pulse and read data back to the owning requester. It also enforces store-first priority, a fetch starvation guard, I/O back-pressure on stores, and flush of speculative requests.

## Interface
- FETCH_STARVE_LIMIT, 4: consecutive load/store grants allowed while a fetch is pending before the fetch is forced to win.
- IO_ADDR_HI, 2'b11: value of addr[17:16] that marks an I/O address.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ena  in  1  global ready; when low, all state holds and ok pulses are driven low
- in_flush  in  1  misprediction flush; kills pending and in-flight fetch/load
- in_io_full  in  1  I/O output buffer full; blocks I/O-address stores
- in_fetch_req  in  1  fetch request level; held with addr stable until out_fetch_ok
- in_fetch_addr  in  32  fetch address; always a 4-byte read
- out_fetch_ok  out  1  one-cycle completion pulse
- out_fetch_data  out  32  instruction word; valid with ok, held until the next fetch completion
- in_load_req  in  1  load request level
- in_load_addr  in  32  load address
- in_load_size  in  3  load size in bytes: 1, 2 or 4
- out_load_ok  out  1  one-cycle completion pulse
- out_load_data  out  32  zero-extended load data; held until the next load completion
- in_store_req  in  1  store request level
- in_store_addr  in  32  store address
- in_store_size  in  3  store size in bytes: 1, 2 or 4
- in_store_data  in  32  store data
- out_store_ok  out  1  one-cycle completion pulse
- out_mem_ena  out  1  one-cycle request pulse to the memory unit
- out_mem_iswrite  out  1  1 = write
- out_mem_addr  out  32  request address
- out_mem_size  out  3  request size in bytes
- out_mem_data  out  32  write data
- in_mem_ok  in  1  memory unit completion pulse
- in_mem_data  in  32  memory unit read data, valid with in_mem_ok
- out_busy  out  1  high in the BUSY and DONE states

## Operation
- States: IDLE, BUSY, DONE. An owner register holds one of FETCH, LOAD, STORE. A `discard` flag and a streak counter are kept alongside.
- A requester is eligible in IDLE if its req is high and:
  - Store: not an I/O store (addr[17:16]==IO_ADDR_HI) while in_io_full is high.
  - Fetch and load: in_flush is low in that cycle.
- Grant priority: store > load > fetch.
- Starvation override: if fetch is eligible and streak ≥ FETCH_STARVE_LIMIT, fetch wins.
- Streak counter:
  - Increments, saturating, on each load or store grant made while in_fetch_req is high.
  - Clears on a fetch grant, and on any grant made while in_fetch_req is low.
- IDLE → BUSY on a grant:
  - out_mem_ena pulses for one cycle.
  - out_mem_addr, out_mem_size, out_mem_iswrite and out_mem_data are registered from the winner.
  - Fetch is issued with size=4 and iswrite=0.
  - The owner is latched and discard is cleared.
- BUSY:
  - If in_flush is high and owner is FETCH or LOAD, set discard. The memory transaction is not aborted.
  - On in_mem_ok, go to DONE:
    - If not discarded: pulse the owner's ok, and register in_mem_data into out_fetch_data (FETCH) or out_load_data (LOAD).
    - If discarded: no ok pulse, and the data registers are unchanged.
- DONE → IDLE unconditionally after one cycle. No requests are sampled in DONE. This guarantees a requester that drops req on the edge sampling its ok is never re-issued.
- Stores are never discarded by flush.
- Reset, including mid-transaction:
  - State IDLE, owner FETCH, discard 0, streak 0.
  - All outputs 0: out_mem_ena, out_mem_iswrite, out_mem_addr, out_mem_size, out_mem_data, out_fetch_ok, out_load_ok, out_store_ok, out_fetch_data, out_load_data, out_busy.
  - The memory unit shares rst, so no stale in_mem_ok is expected.

## Timing
- A req high in IDLE cycle c gives out_mem_ena high in cycle c+1.
- in_mem_ok in cycle m gives the owner's ok and data in cycle m+1 (DONE); IDLE resumes in cycle m+2.
- Back-to-back turnaround: at most one request is issued per three cycles plus memory latency.
- Flush arriving in the same cycle as in_mem_ok still discards.
- Flush in the IDLE grant cycle blocks fetch and load but not a store grant.
- When ena is low, no transitions occur and no counter updates; the ok outputs are forced low for those cycles.
- out_mem_ena is never high for two consecutive cycles.

## Test plan
- Single fetch, addr 0x1000, memory returns 0x00A00093 after 5 cycles -> out_mem_ena one cycle after req with size=4 and iswrite=0; out_fetch_ok pulses once with data 0x00A00093.
- Store, load and fetch all requesting in the same cycle -> grant order is store, load, fetch; each requester gets exactly one ok; out_mem_ena pulses 3 times.
- Continuous load/store traffic with fetch pending, limit 4 -> fetch is granted after exactly 4 LS grants, then the streak resets.
- Store to 0x30000 with in_io_full=1 while a load is pending -> the load is granted and the store waits; after in_io_full drops, the store is issued; out_mem_data and out_mem_addr equal the store's values.
- Load in flight, in_flush pulsed mid-BUSY -> no out_load_ok, out_load_data unchanged, return to IDLE after in_mem_ok; a committed store issued during the same episode still completes.
- rst asserted during BUSY -> next cycle all outputs are 0 and state is IDLE; a new fetch then completes normally.
